wb_uart_rx: RTL and testbench
=============================

# wb_uart_rx

UART receiver with a Wishbone slave register interface and a receive FIFO. It samples the `uart_rx_i` pin on the SoC boundary and deframes 8N1 serial bytes into a FIFO. The CPU or external bus master reads those bytes through the `wb_mux` UART window. It complements the transmit-only `wb_uart` and raises a level interrupt while data is pending.

## Interface
- `WB_DATA_WIDTH`, 32: bus data width; only bits [7:0] and the status bits are meaningful.
- `WB_ADDR_WIDTH`, 32: bus address width; only `wb_addr_i[3:2]` is decoded.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; even, ≥ 4.
- `FIFO_DEPTH`, 8: receive FIFO entries; power of 2, ≥ 2.

Ports:
- `clk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  reset; synchronous, active-low (0 = reset).
- `uart_rx_i`  in  1  asynchronous serial input; idle level is high.
- `wb_addr_i`  in  WB_ADDR_WIDTH  register address.
- `wb_data_i`  in  WB_DATA_WIDTH  write data.
- `wb_sel_i`  in  4  byte selects; ignored, all accesses are treated as full-word.
- `wb_we_i`  in  1  write enable.
- `wb_stb_i`  in  1  strobe.
- `wb_cyc_i`  in  1  cycle.
- `wb_ack_o`  out  1  acknowledge.
- `wb_data_o`  out  WB_DATA_WIDTH  read data.
- `rx_irq_o`  out  1  interrupt: `ie & !empty`.

## Operation
Registers, selected by `wb_addr_i[3:2]`:
- **0 RXDATA (R):** returns `{24'b0, head byte}` and pops the FIFO. When the FIFO is empty it returns 0 and no pointer moves. Writes are ignored.
- **1 STATUS (R/W1C):**
  - bit0 `not_empty`
  - bit1 `overrun` (sticky)
  - bit2 `frame_err` (sticky)
  - bits[7:4] `count`, saturated to 15
  - Writing 1 to bit1 or bit2 clears that bit. All other bits are read-only.
- **2 CTRL (R/W):** bit0 `ie`; all other bits read 0.
- **3:** reads 0; writes are ignored.

Input path: a 2-flop synchronizer on `uart_rx_i` produces `rxs`.

Receiver FSM:
- **IDLE:** arms only after `rxs` has been sampled high at least once since reset. Once armed, `rxs==0` starts a counter and moves to START.
- **START:** at count `CLKS_PER_BIT/2-1`, sample `rxs`.
  - 1 → glitch; return to IDLE with no flag set.
  - 0 → go to DATA.
- **DATA:** sample every `CLKS_PER_BIT` cycles. 8 bits, LSB first, shifted into a shift register.
- **STOP:** sample after a further `CLKS_PER_BIT` cycles.
  - 1 → push the byte.
  - 0 → set `frame_err` and discard the byte.
  - Either way return to IDLE in the next cycle, at mid-stop-bit. This allows a start bit to follow immediately.

FIFO behaviour:
- A push when full with no simultaneous pop drops the new byte and sets `overrun`. The FIFO contents are preserved.
- A push and a pop in the same cycle are both performed, including when the FIFO is full. `count` is unchanged.
- Read and write pointers wrap modulo `FIFO_DEPTH`. Full and empty are distinguished by an extra pointer bit.

A W1C write and a same-cycle set of the same flag: the set wins.

## Timing
Reset values:
- `wb_ack_o` = 0, `wb_data_o` = 0, `rx_irq_o` = 0
- FIFO empty, `ie` = 0, flags = 0, FSM in IDLE and unarmed
- Synchronizer flops = 1

Reset mid-frame abandons the frame. Nothing is pushed.

Bus handshake:
- `wb_ack_o` rises the cycle after `stb & cyc & !ack`. It is high for exactly one cycle.
- Back-to-back accesses therefore take 2 cycles each.
- `wb_data_o` is valid in the ack cycle and holds 0 otherwise.
- The pop and W1C side effects occur on the ack edge.

Receive latency:
- t0 = first cycle with `rxs==0` in armed IDLE.
- The stop sample occurs at t0 + `CLKS_PER_BIT/2` + 9×`CLKS_PER_BIT`.
- The byte is visible (`not_empty`, `rx_irq_o`) in the cycle after the stop sample.
- The pin-to-`rxs` delay is 2 cycles.

`rx_irq_o` is registered. It falls in the cycle after the ack that empties the FIFO.

## Test plan
1. Serial byte 0xA5, `CLKS_PER_BIT`=16 → STATUS reads 0x11; RXDATA reads 0x000000A5; STATUS then reads 0x00.
2. Nine bytes 0x01..0x09 sent with no reads, `FIFO_DEPTH`=8 → STATUS reads 0x83. Eight reads return 0x01..0x08 and a ninth returns 0. Write 0x2 to STATUS → bit1 clears.
3. Frame 0x3C with stop bit = 0 → FIFO stays empty and STATUS reads 0x04. Write 0x4 → STATUS reads 0x00. Next valid byte 0x55 is received correctly.
4. Low pulse of 4 cycles on the idle line → no push and no flags set; FSM back in IDLE.
5. CTRL = 1, then receive 0x7E → `rx_irq_o` rises exactly 1 cycle after the stop sample. It stays high until the RXDATA read ack and is low the following cycle.
6. Reset asserted during the DATA bits of a frame, with the line held low at release → no push. The line going high, then a byte 0x42 → 0x42 received correctly. Reads of RXDATA while empty return 0 without underflow.

Source files
------------

// File: rtl/wb_uart_rx.sv
// 8N1 UART receiver with a receive FIFO, read through a small Wishbone register window.
// Registers: 0 RXDATA (read pops), 1 STATUS (W1C flags), 2 CTRL (ie), 3 reserved.
module wb_uart_rx #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int CLKS_PER_BIT  = 16,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     uart_rx_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  input  logic [3:0]               wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_cyc_i,
  output logic                     wb_ack_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic                     rx_irq_o
);

  // state   | meaning
  // S_IDLE  | waiting for a start edge (only once armed)
  // S_START | counting to mid start bit, rejecting glitches
  // S_DATA  | sampling 8 data bits, LSB first
  // S_STOP  | sampling the stop bit, then push or flag frame_err
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic          sync1_q, sync2_q, rxs;
  logic [1:0]    vld_q, vld_d;
  logic          armed_q, armed_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push, ferr_set;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count, count_d;
  logic          empty, full, pop, push_ok, ovr_set;
  logic [3:0]    cnt_sat;

  logic          ie_q, ie_d, ovr_q, ovr_d, ferr_q, ferr_d;
  logic          ack_q, ack_d, irq_q, irq_d;
  logic [1:0]    reg_sel;
  logic          rd_acc, wr_acc;
  logic [WB_DATA_WIDTH-1:0] rdata;

  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_addr_i[WB_ADDR_WIDTH-1:4], wb_addr_i[1:0],
                         wb_data_i[WB_DATA_WIDTH-1:3]};

  assign rxs = sync2_q;

  // Arming ignores the preset synchronizer value: a line held low through reset must not start a frame.
  always_comb begin
    vld_d    = {vld_q[0], 1'b1};
    armed_d  = armed_q | (vld_q[1] & rxs);
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (armed_q && !rxs) begin
          state_d = S_START;
          cnt_d   = HALF_M1;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = BIT_M1;
            bit_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rxs, shift_q[7:1]};
          cnt_d   = BIT_M1;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (rxs) push     = 1'b1;
          else     ferr_set = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign reg_sel = wb_addr_i[3:2];
  assign rd_acc  = ack_q & ~wb_we_i;
  assign wr_acc  = ack_q & wb_we_i;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = rd_acc & (reg_sel == 2'd0) & ~empty;
  assign push_ok = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    count_d  = wr_ptr_d - rd_ptr_d;

    ack_d  = wb_stb_i & wb_cyc_i & ~ack_q;
    ie_d   = ie_q;
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (wr_acc && reg_sel == 2'd2) ie_d = wb_data_i[0];
    if (wr_acc && reg_sel == 2'd1) begin
      if (wb_data_i[1]) ovr_d  = 1'b0;
      if (wb_data_i[2]) ferr_d = 1'b0;
    end
    // Hardware set takes priority over a same-cycle clear.
    if (ovr_set)  ovr_d  = 1'b1;
    if (ferr_set) ferr_d = 1'b1;
    irq_d = ie_d & (count_d != '0);
  end

  always_comb begin
    cnt_sat = (32'(count) > 32'd15) ? 4'hF : 4'(count);
    rdata   = '0;
    case (reg_sel)
      2'd0: if (!empty) rdata[7:0] = mem_q[rd_ptr_q[AW-1:0]];
      2'd1: begin
        rdata[0]   = ~empty;
        rdata[1]   = ovr_q;
        rdata[2]   = ferr_q;
        rdata[7:4] = cnt_sat;
      end
      2'd2: rdata[0] = ie_q;
      default: rdata = '0;
    endcase
    wb_data_o = ack_q ? rdata : '0;
  end

  assign wb_ack_o = ack_q;
  assign rx_irq_o = irq_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      vld_q    <= 2'b00;
      armed_q  <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ie_q     <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      ack_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      sync1_q  <= uart_rx_i;
      sync2_q  <= sync1_q;
      vld_q    <= vld_d;
      armed_q  <= armed_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ie_q     <= ie_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      ack_q    <= ack_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

endmodule

// File: tb/tb_wb_uart_rx.sv
// Directed bench for wb_uart_rx: bus reads push expected data into a scoreboard,
// an ack-driven monitor pops and compares.
module tb_wb_uart_rx;
  localparam int CPB = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        uart_rx_i = 1'b1;
  logic [31:0] wb_addr_i = '0;
  logic [31:0] wb_data_i = '0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_we_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_ack_o;
  logic [31:0] wb_data_o;
  logic        rx_irq_o;

  wb_uart_rx #(.WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .uart_rx_i(uart_rx_i),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .wb_data_o(wb_data_o), .rx_irq_o(rx_irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
    logic        chk;
    string       name;
  } sb_t;

  sb_t sb_q[$];
  int  tests = 0;
  int  fails = 0;

  always @(negedge clk_i) begin : monitor
    sb_t e;
    if (rst_i && wb_ack_o) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: got data %h, want no ack", wb_data_o);
      end else begin
        e = sb_q.pop_front();
        if (e.chk) begin
          tests++;
          if ((wb_data_o & e.mask) !== e.exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", e.name, wb_data_o & e.mask, e.exp);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] wd,
                         input logic chk, input logic [31:0] exp, input logic [31:0] mask,
                         input string name, output logic irq_at_ack);
    sb_t e;
    bit  got;
    e.exp = exp; e.mask = mask; e.chk = chk; e.name = name;
    sb_q.push_back(e);
    wb_addr_i = {28'b0, a, 2'b00};
    wb_we_i   = we;
    wb_data_i = wd;
    wb_stb_i  = 1'b1;
    wb_cyc_i  = 1'b1;
    got = 0;
    irq_at_ack = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk_i);
      #1;
      if (wb_ack_o) begin
        got = 1;
        irq_at_ack = rx_irq_o;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s_ack_timeout: got no ack, want ack within 8 cycles", name);
      e = sb_q.pop_back();
    end
    @(posedge clk_i);
    #1;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    if (got) check({name, "_ack_pulse"}, {31'b0, wb_ack_o}, 32'd0);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    logic dummy;
    wb_xfer(1'b0, a, 32'd0, 1'b1, exp, 32'hFFFF_FFFF, name, dummy);
  endtask

  task automatic rd_m(input logic [1:0] a, input logic [31:0] exp, input logic [31:0] mask,
                      input string name);
    logic dummy;
    wb_xfer(1'b0, a, 32'd0, 1'b1, exp, mask, name, dummy);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input string name);
    logic dummy;
    wb_xfer(1'b1, a, d, 1'b0, 32'd0, 32'd0, name, dummy);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx_i = bits[i];
      repeat (CPB) @(posedge clk_i);
      #1;
    end
    uart_rx_i = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic irq_ack;
    logic [7:0] b;

    // Reset values
    idle(4);
    check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
    check("rst_data", wb_data_o, 32'd0);
    check("rst_irq", {31'b0, rx_irq_o}, 32'd0);
    rst_i = 1'b1;
    idle(6);
    rd(2'd1, 32'h00, "rst_status");
    rd(2'd2, 32'h00, "rst_ctrl");

    // 1: single byte
    send_frame(8'hA5, 1'b1);
    idle(4);
    rd(2'd1, 32'h11, "t1_status");
    rd(2'd0, 32'hA5, "t1_data");
    rd(2'd1, 32'h00, "t1_status_after");

    // 2: overrun
    for (int i = 1; i <= 9; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1);
    end
    idle(4);
    rd(2'd1, 32'h83, "t2_status_full");
    for (int i = 1; i <= 8; i++) rd(2'd0, 32'(i), $sformatf("t2_data%0d", i));
    rd(2'd0, 32'h00, "t2_data_empty");
    rd(2'd1, 32'h02, "t2_status_ovr");
    wr(2'd1, 32'h2, "t2_w1c");
    rd(2'd1, 32'h00, "t2_status_clr");

    // 3: framing error
    send_frame(8'h3C, 1'b0);
    idle(20);
    rd(2'd1, 32'h04, "t3_status_ferr");
    wr(2'd1, 32'h4, "t3_w1c");
    rd(2'd1, 32'h00, "t3_status_clr");
    send_frame(8'h55, 1'b1);
    idle(4);
    rd(2'd1, 32'h11, "t3_status_55");
    rd(2'd0, 32'h55, "t3_data_55");

    // 4: glitch
    uart_rx_i = 1'b0;
    idle(4);
    uart_rx_i = 1'b1;
    idle(30);
    rd(2'd1, 32'h00, "t4_status");
    wr(2'd3, 32'hFFFF_FFFF, "t4_wr_reg3");
    rd(2'd3, 32'h00, "t4_reg3");
    wr(2'd0, 32'hFFFF_FFFF, "t4_wr_rxdata");
    rd(2'd1, 32'h00, "t4_status_after_wr");

    // 5: interrupt timing
    wr(2'd2, 32'hFFFF_FFFF, "t5_ctrl_wr");
    rd(2'd2, 32'h01, "t5_ctrl");
    check("t5_irq_idle", {31'b0, rx_irq_o}, 32'd0);
    fork
      send_frame(8'h7E, 1'b1);
      begin
        repeat (154) @(posedge clk_i);
        #1;
        check("t5_irq_at_stop", {31'b0, rx_irq_o}, 32'd0);
        @(posedge clk_i);
        #1;
        check("t5_irq_rise", {31'b0, rx_irq_o}, 32'd1);
      end
    join
    idle(10);
    check("t5_irq_held", {31'b0, rx_irq_o}, 32'd1);
    wb_xfer(1'b0, 2'd0, 32'd0, 1'b1, 32'h7E, 32'hFFFF_FFFF, "t5_data", irq_ack);
    check("t5_irq_at_ack", {31'b0, irq_ack}, 32'd1);
    check("t5_irq_fall", {31'b0, rx_irq_o}, 32'd0);

    // 6: reset mid-frame
    uart_rx_i = 1'b0;
    idle(60);
    rst_i = 1'b0;
    idle(3);
    rst_i = 1'b1;
    idle(200);
    uart_rx_i = 1'b1;
    idle(40);
    rd(2'd2, 32'h00, "t6_ctrl_reset");
    rd_m(2'd1, 32'h00, 32'hF1, "t6_status_nopush");
    send_frame(8'h42, 1'b1);
    idle(4);
    rd_m(2'd1, 32'h11, 32'hF1, "t6_status_42");
    rd(2'd0, 32'h42, "t6_data_42");
    rd(2'd0, 32'h00, "t6_empty_rd1");
    rd(2'd0, 32'h00, "t6_empty_rd2");
    rd_m(2'd1, 32'h00, 32'hF1, "t6_status_end");

    idle(4);
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL sb_leftover: got %0d entries, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
